// File: rtl/cnn_weight_pkg.sv
// Shared widths, index helpers and FSM encoding for the
// CNN weight prefetch slice.
package cnn_weight_pkg;

    function automatic int kernel_bits(input int k, input int w);
        return k * k * w;
    endfunction

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN
    } wpf_state_e;

endpackage

// File: rtl/wpf_fifo2.sv
// Two-entry FIFO with registered storage; slot0 is always the head,
// so a same-cycle push and pop keeps arrival order.
module wpf_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic          valid_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] slot0_q, slot0_d;
    logic [DW-1:0] slot1_q, slot1_d;
    logic [1:0]    count_q, count_d;
    logic          do_pop;
    logic          do_push;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b11: begin
                if (count_q == 2'd1) begin
                    slot0_d = push_data_i;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = push_data_i;
                end
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            2'b10: begin
                if (count_q == 2'd0) begin
                    slot0_d = push_data_i;
                end else begin
                    slot1_d = push_data_i;
                end
                count_d = count_q + 2'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = slot0_q;
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/weight_prefetch.sv
// Sweeps (filter, channel) pairs, fetches kernels from the weight ROM
// into a 2-deep buffer. Optional WEIGHT_PREFETCH_PERF_EN adds stall_cycles.
module weight_prefetch
    import cnn_weight_pkg::*;
#(
    parameter int NUM_FILTERS    = 3,
    parameter int INPUT_CHANNELS = 3,
    parameter int KERNEL_SIZE    = 3,
    parameter int WEIGHT_WIDTH   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic sweep_done,
    output logic [idx_bits(NUM_FILTERS)-1:0]    rom_filter_idx,
    output logic [idx_bits(INPUT_CHANNELS)-1:0] rom_channel_idx,
    output logic rom_read_en,
    input  logic [kernel_bits(KERNEL_SIZE, WEIGHT_WIDTH)-1:0] rom_weight,
    input  logic rom_weight_valid,
    output logic [kernel_bits(KERNEL_SIZE, WEIGHT_WIDTH)-1:0] w_data,
    output logic [idx_bits(NUM_FILTERS)-1:0]    w_filter,
    output logic [idx_bits(INPUT_CHANNELS)-1:0] w_channel,
    output logic w_last,
    output logic w_valid,
`ifdef WEIGHT_PREFETCH_PERF_EN
    output logic [31:0] stall_cycles,
`endif
    input  logic w_ready
);

    localparam int KW = kernel_bits(KERNEL_SIZE, WEIGHT_WIDTH);
    localparam int FW = idx_bits(NUM_FILTERS);
    localparam int CW = idx_bits(INPUT_CHANNELS);
    localparam int PW = KW + FW + CW + 1;
    localparam logic [FW-1:0] FIL_LAST = FW'(NUM_FILTERS - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(INPUT_CHANNELS - 1);

    wpf_state_e    state_q;
    logic [FW-1:0] fil_q;
    logic [CW-1:0] ch_q;
    logic [FW-1:0] rom_fil_q;
    logic [CW-1:0] rom_ch_q;
    logic          busy_q;
    logic          done_q;
    logic          rd_en_q;

    logic          is_last;
    logic          push;
    logic          pop;
    logic [PW-1:0] push_data;
    logic [PW-1:0] head;
    logic [1:0]    count;

    assign is_last   = (fil_q == FIL_LAST) && (ch_q == CH_LAST);
    assign push      = (state_q == WAIT) && rom_weight_valid;
    assign pop       = w_valid && w_ready;
    assign push_data = {rom_weight, fil_q, ch_q, is_last};

    wpf_fifo2 #(
        .DW (PW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .valid_o     (w_valid),
        .count_o     (count)
    );

    assign {w_data, w_filter, w_channel, w_last} = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            fil_q     <= '0;
            ch_q      <= '0;
            rom_fil_q <= '0;
            rom_ch_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        fil_q   <= '0;
                        ch_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A free slot now guarantees room at capture time.
                    if (count < 2'd2) begin
                        rom_fil_q <= fil_q;
                        rom_ch_q  <= ch_q;
                        rd_en_q   <= 1'b1;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (rom_weight_valid) begin
                        if (is_last) begin
                            state_q <= DRAIN;
                        end else begin
                            if (ch_q == CH_LAST) begin
                                ch_q  <= '0;
                                fil_q <= fil_q + FW'(1);
                            end else begin
                                ch_q <= ch_q + CW'(1);
                            end
                            state_q <= ISSUE;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && w_last) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy            = busy_q;
    assign sweep_done      = done_q;
    assign rom_read_en     = rd_en_q;
    assign rom_filter_idx  = rom_fil_q;
    assign rom_channel_idx = rom_ch_q;

`ifdef WEIGHT_PREFETCH_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            stall_q <= '0;
        end else if (busy_q && w_ready && !w_valid
                     && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_weight_prefetch.sv
// Randomized self-checking bench for weight_prefetch with a
// latency-accurate ROM model and an in-order kernel scoreboard.
module tb_weight_prefetch;

    localparam int NF  = 3;
    localparam int NC  = 3;
    localparam int K   = 3;
    localparam int W   = 16;
    localparam int KW  = K * K * W;
    localparam int NK  = NF * NC;
    localparam int LAT = K * K + 1;
    localparam int FW  = $clog2(NF);
    localparam int CW  = $clog2(NC);

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic busy, sweep_done, rom_read_en;
    logic [FW-1:0] rom_filter_idx, w_filter;
    logic [CW-1:0] rom_channel_idx, w_channel;
    logic [KW-1:0] rom_weight = '0;
    logic rom_weight_valid = 1'b0;
    logic [KW-1:0] w_data;
    logic w_last, w_valid;
    logic w_ready = 1'b0;
`ifdef WEIGHT_PREFETCH_PERF_EN
    logic [31:0] stall_cycles;
`endif

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    weight_prefetch #(
        .NUM_FILTERS    (NF),
        .INPUT_CHANNELS (NC),
        .KERNEL_SIZE    (K),
        .WEIGHT_WIDTH   (W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .busy             (busy),
        .sweep_done       (sweep_done),
        .rom_filter_idx   (rom_filter_idx),
        .rom_channel_idx  (rom_channel_idx),
        .rom_read_en      (rom_read_en),
        .rom_weight       (rom_weight),
        .rom_weight_valid (rom_weight_valid),
        .w_data           (w_data),
        .w_filter         (w_filter),
        .w_channel        (w_channel),
        .w_last           (w_last),
        .w_valid          (w_valid),
`ifdef WEIGHT_PREFETCH_PERF_EN
        .stall_cycles     (stall_cycles),
`endif
        .w_ready          (w_ready)
    );

    wire [KW+2*FW+2*CW+5:0] all_outs = {busy, sweep_done,
        rom_read_en, rom_filter_idx, rom_channel_idx, w_data,
        w_filter, w_channel, w_last, w_valid};

    // ROM contents; word i of kernel (f,c) sits at (f*NC+c)*K*K+i
    logic [W-1:0] rom_mem [NK*K*K];

    function automatic logic [KW-1:0] exp_data(input int f, input int c);
        logic [KW-1:0] d;
        for (int i = 0; i < K * K; i++)
            d[i*W +: W] = rom_mem[(f * NC + c) * K * K + i];
        return d;
    endfunction

    int rom_cnt = 0;
    int rom_f = 0;
    int rom_c = 0;
    bit inject = 1'b0;

    always @(negedge clk) begin
        rom_weight_valid = 1'b0;
        if (!rst_n) begin
            rom_cnt = 0;
        end else begin
            if (rom_cnt > 0) begin
                rom_cnt--;
                if (rom_cnt == 0) begin
                    rom_weight = exp_data(rom_f, rom_c);
                    rom_weight_valid = 1'b1;
                end
            end
            if (rom_read_en) begin
                rom_cnt = LAT;
                rom_f = int'(rom_filter_idx);
                rom_c = int'(rom_channel_idx);
            end
            if (inject) begin
                rom_weight = {KW{1'b1}};
                rom_weight_valid = 1'b1;
                inject = 1'b0;
            end
        end
    end

    typedef struct {
        int f;
        int c;
        bit l;
        logic [KW-1:0] d;
    } rec_t;

    rec_t got[$];
    int n_rd = 0;
    int n_done = 0;
    bit done_busy_bad = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (w_valid && w_ready) begin
                rec_t r;
                r.f = int'(w_filter);
                r.c = int'(w_channel);
                r.l = w_last;
                r.d = w_data;
                got.push_back(r);
            end
            if (rom_read_en) n_rd++;
            if (sweep_done) begin
                n_done++;
                if (busy) done_busy_bad = 1'b1;
            end
        end
    end

    task automatic clear_mon();
        got.delete();
        n_rd = 0;
        n_done = 0;
        done_busy_bad = 1'b0;
    endtask

    task automatic fill_rom(input bit rnd);
        for (int i = 0; i < NK * K * K; i++)
            rom_mem[i] = rnd ? W'($urandom) : W'(i);
    endtask

    task automatic do_start();
        @(posedge clk) #1;
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input bit rnd);
        for (int i = 0; i < bound && n_done == 0; i++) begin
            if (rnd) w_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk) #1;
        end
        w_ready = 1'b1;
        repeat (4) @(posedge clk) #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (all_outs !== '0)
            $display("FAIL reset_outs got=%h want=0", all_outs);
        else passed++;
        repeat (2) @(posedge clk) #1;
        rst_n = 1'b1;
        @(posedge clk) #1;
        inject = 1'b1;
        repeat (3) @(posedge clk) #1;
        total++;
        if ({busy, w_valid} !== 2'b00)
            $display("FAIL idle_valid_ignored busy,w_valid=%b want 00",
                     {busy, w_valid});
        else passed++;
    endtask

    task automatic test_full_sweep();
        fill_rom(1'b0);
        clear_mon();
        w_ready = 1'b1;
        do_start();
        total++;
        if (busy !== 1'b1) $display("FAIL busy_on_start got=%b want=1", busy);
        else passed++;
        wait_done(400, 1'b0);
        total++;
        if (n_done !== 1 || done_busy_bad || busy !== 1'b0)
            $display("FAIL full_done done=%0d bad=%0d busy=%b want 1/0/0",
                     n_done, done_busy_bad, busy);
        else passed++;
        total++;
        if (n_rd !== NK) $display("FAIL full_reads got=%0d want=%0d", n_rd, NK);
        else passed++;
        total++;
        if (got.size() !== NK)
            $display("FAIL full_count got=%0d want=%0d", got.size(), NK);
        else passed++;
        for (int i = 0; i < got.size() && i < NK; i++) begin
            total++;
            if (got[i].f !== i / NC || got[i].c !== i % NC ||
                got[i].l !== (i == NK - 1) ||
                got[i].d !== exp_data(i / NC, i % NC))
                $display("FAIL full_seq[%0d] got f%0d c%0d l%0d want f%0d c%0d l%0d",
                         i, got[i].f, got[i].c, got[i].l,
                         i / NC, i % NC, (i == NK - 1));
            else passed++;
        end
        if (got.size() > 5) begin
            for (int i = 0; i < K * K; i++) begin
                total++;
                if (got[5].d[i*W +: W] !== W'(8'h2D + i))
                    $display("FAIL kern12_w%0d got=%h want=%h", i,
                             got[5].d[i*W +: W], W'(8'h2D + i));
                else passed++;
            end
        end
`ifdef WEIGHT_PREFETCH_PERF_EN
        total++;
        if (stall_cycles !== 32'((LAT + 2) + (NK - 1) * (LAT + 1)))
            $display("FAIL stall_cycles got=%0d want=%0d", stall_cycles,
                     (LAT + 2) + (NK - 1) * (LAT + 1));
        else passed++;
        do_start();
        total++;
        if (stall_cycles !== 32'd0)
            $display("FAIL stall_clear got=%0d want=0", stall_cycles);
        else passed++;
        clear_mon();
        wait_done(400, 1'b0);
`endif
    endtask

    task automatic test_back_pressure();
        logic [KW-1:0] snap;
        bit held;
        fill_rom(1'b1);
        clear_mon();
        w_ready = 1'b0;
        held = 1'b0;
        snap = '0;
        do_start();
        for (int i = 0; i < 40; i++) begin
            if (w_valid) begin
                if (held) begin
                    total++;
                    if (w_data !== snap || w_filter !== '0 || w_channel !== '0)
                        $display("FAIL bp_stable cyc%0d got=%h want=%h",
                                 i, w_data, snap);
                    else passed++;
                end
                snap = w_data;
                held = 1'b1;
            end
            @(posedge clk) #1;
        end
        total++;
        if (n_rd !== 2 || got.size() !== 0)
            $display("FAIL bp_reads got rd=%0d pops=%0d want 2/0",
                     n_rd, got.size());
        else passed++;
        w_ready = 1'b1;
        wait_done(400, 1'b0);
        total++;
        if (got.size() !== NK || n_done !== 1)
            $display("FAIL bp_count got=%0d/%0d want=%0d/1",
                     got.size(), n_done, NK);
        else passed++;
        for (int i = 0; i < got.size() && i < NK; i++) begin
            total++;
            if (got[i].f !== i / NC || got[i].c !== i % NC ||
                got[i].d !== exp_data(i / NC, i % NC))
                $display("FAIL bp_seq[%0d] got f%0d c%0d want f%0d c%0d",
                         i, got[i].f, got[i].c, i / NC, i % NC);
            else passed++;
        end
    endtask

    task automatic test_mid_start();
        fill_rom(1'b1);
        clear_mon();
        w_ready = 1'b1;
        do_start();
        repeat (30) @(posedge clk) #1;
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        wait_done(400, 1'b0);
        total++;
        if (got.size() !== NK || n_done !== 1 || n_rd !== NK)
            $display("FAIL mid_start got pops=%0d done=%0d rd=%0d want %0d/1/%0d",
                     got.size(), n_done, n_rd, NK, NK);
        else passed++;
        for (int i = 0; i < got.size() && i < NK; i++) begin
            total++;
            if (got[i].f !== i / NC || got[i].c !== i % NC ||
                got[i].d !== exp_data(i / NC, i % NC))
                $display("FAIL mid_seq[%0d] got f%0d c%0d want f%0d c%0d",
                         i, got[i].f, got[i].c, i / NC, i % NC);
            else passed++;
        end
    endtask

    task automatic test_push_pop();
        fill_rom(1'b1);
        clear_mon();
        w_ready = 1'b0;
        do_start();
        for (int i = 0; i < 100 && !w_valid; i++) @(posedge clk) #1;
        for (int i = 0; i < 100 && rom_cnt != 1; i++) @(posedge clk) #1;
        // ROM valid lands on the next edge: pop the head on that edge too
        w_ready = 1'b1;
        @(posedge clk) #1;
        w_ready = 1'b0;
        total++;
        if (got.size() !== 1 || w_valid !== 1'b1 ||
            w_filter !== FW'(0) || w_channel !== CW'(1))
            $display("FAIL pp_head got pops=%0d v=%b f%0d c%0d want 1/1/f0 c1",
                     got.size(), w_valid, w_filter, w_channel);
        else passed++;
        @(posedge clk) #1;
        w_ready = 1'b1;
        @(posedge clk) #1;
        w_ready = 1'b0;
        total++;
        if (w_valid !== 1'b0 || got.size() !== 2)
            $display("FAIL pp_count got v=%b pops=%0d want 0/2",
                     w_valid, got.size());
        else passed++;
        w_ready = 1'b1;
        wait_done(400, 1'b0);
        total++;
        if (got.size() !== NK || n_done !== 1)
            $display("FAIL pp_total got=%0d/%0d want=%0d/1",
                     got.size(), n_done, NK);
        else passed++;
        for (int i = 0; i < got.size() && i < NK; i++) begin
            total++;
            if (got[i].f !== i / NC || got[i].c !== i % NC ||
                got[i].d !== exp_data(i / NC, i % NC))
                $display("FAIL pp_seq[%0d] got f%0d c%0d want f%0d c%0d",
                         i, got[i].f, got[i].c, i / NC, i % NC);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        fill_rom(1'b1);
        clear_mon();
        w_ready = 1'b1;
        seen = 1'b0;
        do_start();
        for (int i = 0; i < 300 && !seen; i++) begin
            if (rom_read_en && rom_filter_idx == FW'(1) &&
                rom_channel_idx == CW'(1)) seen = 1'b1;
            else @(posedge clk) #1;
        end
        total++;
        if (!seen) $display("FAIL rst_mid_reach got=0 want=1");
        else passed++;
        repeat (3) @(posedge clk) #1;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (all_outs !== '0)
            $display("FAIL rst_mid_async got=%h want=0", all_outs);
        else passed++;
        @(posedge clk) #1;
        total++;
        if (all_outs !== '0 || n_done !== 0)
            $display("FAIL rst_mid_edge got=%h done=%0d want 0/0",
                     all_outs, n_done);
        else passed++;
        rst_n = 1'b1;
        repeat (2) @(posedge clk) #1;
        clear_mon();
        do_start();
        wait_done(400, 1'b0);
        total++;
        if (got.size() !== NK || n_done !== 1)
            $display("FAIL rst_resweep got=%0d/%0d want=%0d/1",
                     got.size(), n_done, NK);
        else passed++;
        for (int i = 0; i < got.size() && i < NK; i++) begin
            total++;
            if (got[i].f !== i / NC || got[i].c !== i % NC ||
                got[i].d !== exp_data(i / NC, i % NC))
                $display("FAIL rst_seq[%0d] got f%0d c%0d want f%0d c%0d",
                         i, got[i].f, got[i].c, i / NC, i % NC);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 3; s++) begin
            fill_rom(1'b1);
            clear_mon();
            do_start();
            wait_done(1500, 1'b1);
            total++;
            if (got.size() !== NK || n_done !== 1 || done_busy_bad)
                $display("FAIL b2b%0d got pops=%0d done=%0d want %0d/1",
                         s, got.size(), n_done, NK);
            else passed++;
            for (int i = 0; i < got.size() && i < NK; i++) begin
                total++;
                if (got[i].f !== i / NC || got[i].c !== i % NC ||
                    got[i].l !== (i == NK - 1) ||
                    got[i].d !== exp_data(i / NC, i % NC))
                    $display("FAIL b2b%0d_seq[%0d] got f%0d c%0d want f%0d c%0d",
                             s, i, got[i].f, got[i].c, i / NC, i % NC);
                else passed++;
            end
        end
    endtask

    initial begin
        fill_rom(1'b0);
        test_reset();
        test_full_sweep();
        test_back_pressure();
        test_mid_start();
        test_push_pop();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
